// File: rtl/fp_mul_rne.sv
// Parametrised floating-point multiplier with round-to-nearest-even.
// Three-stage pipeline: unpack/classify, exponent add and significand multiply,
// then normalise/round/pack. A new start discards any operation still in flight.
// Subnormal operands are treated as zero, and results below the normal range flush to zero.
module fp_mul_rne #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              done,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              overflow,
    output logic              underflow,
    output logic              exception,
    output logic [DATA_W-1:0] res
);

    localparam int PROD_W = 2 * (MAN_W + 1);
    localparam int SUM_W  = EXP_W + 2;

    localparam logic signed [SUM_W-1:0] BIAS_S    = SUM_W'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] EXP_MAX_S = SUM_W'((1 << EXP_W) - 1);
    localparam logic [DATA_W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    // Operand class; reused as the combined special-case code in stage 2.
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    function automatic cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0)
            return CLS_ZERO;
        else if (e == '1)
            return (f == '0) ? CLS_INF : CLS_NAN;
        else
            return CLS_NORM;
    endfunction

    // Stage 1 registers
    logic              s1_valid;
    logic              s1_sign_a, s1_sign_b;
    logic [EXP_W-1:0]  s1_exp_a, s1_exp_b;
    logic [MAN_W-1:0]  s1_frac_a, s1_frac_b;
    cls_t              s1_cls_a, s1_cls_b;

    // Stage 2 registers
    logic                    s2_valid;
    logic                    s2_sign;
    logic signed [SUM_W-1:0] s2_exp_sum;
    logic [PROD_W-1:0]       s2_prod;
    cls_t                    s2_code;

    // Stage 3 combinational results
    logic [PROD_W-2:0]       norm;
    logic signed [SUM_W-1:0] exp_n;
    logic signed [SUM_W-1:0] exp_r;
    logic [MAN_W-1:0]        frac_t;
    logic [MAN_W:0]          frac_r;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic [DATA_W-1:0]       nxt_res;
    logic                    nxt_ov;
    logic                    nxt_un;
    logic                    nxt_ex;

    // Pipeline occupancy: a start always restarts from stage 1 and squashes older ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= start;
            s2_valid <= s1_valid & ~start;
        end
    end

    // Stage 1: capture operand fields and classify each operand.
    always_ff @(posedge clk) begin
        if (start) begin
            s1_sign_a <= op_a[DATA_W-1];
            s1_sign_b <= op_b[DATA_W-1];
            s1_exp_a  <= op_a[DATA_W-2 -: EXP_W];
            s1_exp_b  <= op_b[DATA_W-2 -: EXP_W];
            s1_frac_a <= op_a[MAN_W-1:0];
            s1_frac_b <= op_b[MAN_W-1:0];
            s1_cls_a  <= classify(op_a[DATA_W-2 -: EXP_W], op_a[MAN_W-1:0]);
            s1_cls_b  <= classify(op_b[DATA_W-2 -: EXP_W], op_b[MAN_W-1:0]);
        end
    end

    // Stage 2: sign, biased exponent sum, full-width significand product, special code.
    always_ff @(posedge clk) begin
        s2_sign    <= s1_sign_a ^ s1_sign_b;
        s2_exp_sum <= $signed({2'b00, s1_exp_a}) + $signed({2'b00, s1_exp_b}) - BIAS_S;
        s2_prod    <= PROD_W'({1'b1, s1_frac_a}) * PROD_W'({1'b1, s1_frac_b});
        if (s1_cls_a == CLS_NAN || s1_cls_b == CLS_NAN ||
            (s1_cls_a == CLS_INF && s1_cls_b == CLS_ZERO) ||
            (s1_cls_b == CLS_INF && s1_cls_a == CLS_ZERO))
            s2_code <= CLS_NAN;
        else if (s1_cls_a == CLS_INF || s1_cls_b == CLS_INF)
            s2_code <= CLS_INF;
        else if (s1_cls_a == CLS_ZERO || s1_cls_b == CLS_ZERO)
            s2_code <= CLS_ZERO;
        else
            s2_code <= CLS_NORM;
    end

    // Stage 3: normalise by at most one place, round to nearest even, range-check and pack.
    always_comb begin
        norm     = s2_prod[PROD_W-1] ? s2_prod[PROD_W-2:0] : {s2_prod[PROD_W-3:0], 1'b0};
        exp_n    = s2_exp_sum + $signed({{(SUM_W - 1){1'b0}}, s2_prod[PROD_W-1]});
        frac_t   = norm[PROD_W-2 -: MAN_W];
        guard    = norm[PROD_W-2-MAN_W];
        sticky   = |norm[PROD_W-3-MAN_W:0];
        round_up = guard & (sticky | frac_t[0]);
        frac_r   = {1'b0, frac_t} + {{MAN_W{1'b0}}, round_up};
        exp_r    = exp_n + $signed({{(SUM_W - 1){1'b0}}, frac_r[MAN_W]});

        nxt_res = '0;
        nxt_ov  = 1'b0;
        nxt_un  = 1'b0;
        nxt_ex  = 1'b0;
        case (s2_code)
            CLS_NAN: begin
                nxt_res = QNAN;
                nxt_ex  = 1'b1;
            end
            CLS_INF:  nxt_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_ZERO: nxt_res = {s2_sign, {(EXP_W + MAN_W){1'b0}}};
            default: begin
                if (exp_r >= EXP_MAX_S) begin
                    nxt_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    nxt_ov  = 1'b1;
                end else if (exp_r[SUM_W-1] || exp_r == '0) begin
                    nxt_res = {s2_sign, {(EXP_W + MAN_W){1'b0}}};
                    nxt_un  = 1'b1;
                end else begin
                    nxt_res = {s2_sign, exp_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
                end
            end
        endcase
    end

    // Output register: done drops on start and rises with the result of the surviving op.
    always_ff @(posedge clk) begin
        if (rst) begin
            done      <= 1'b1;
            res       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else if (start) begin
            done <= 1'b0;
        end else if (s2_valid) begin
            done      <= 1'b1;
            res       <= nxt_res;
            overflow  <= nxt_ov;
            underflow <= nxt_un;
            exception <= nxt_ex;
        end
    end

endmodule

// File: tb/tb_fp_mul_rne.sv
// Bench for fp_mul_rne: single- and half-precision instances checked against a
// value-level multiply-and-round model, plus literal vectors that pin the model.
module tb_fp_mul_rne;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // single precision instance
    logic        sp_start = 1'b0;
    logic [31:0] sp_a = '0, sp_b = '0, sp_res;
    logic        sp_done, sp_ov, sp_un, sp_ex;

    // half precision instance
    logic        hp_start = 1'b0;
    logic [15:0] hp_a = '0, hp_b = '0, hp_res;
    logic        hp_done, hp_ov, hp_un, hp_ex;

    fp_mul_rne #(.EXP_W(8), .MAN_W(23)) u_sp (
        .clk(clk), .rst(rst), .start(sp_start), .done(sp_done),
        .op_a(sp_a), .op_b(sp_b), .overflow(sp_ov), .underflow(sp_un),
        .exception(sp_ex), .res(sp_res));

    fp_mul_rne #(.EXP_W(5), .MAN_W(10)) u_hp (
        .clk(clk), .rst(rst), .start(hp_start), .done(hp_done),
        .op_a(hp_a), .op_b(hp_b), .overflow(hp_ov), .underflow(hp_un),
        .exception(hp_ex), .res(hp_res));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Exact product of the two significands, rounded to nearest-even by remainder
    // comparison; subnormal inputs and outputs are zero.
    function automatic void fp_model(input int ew, input int mw,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic ov,
                                     output logic un, output logic ex);
        longint emax, bias, fmask, ea, eb, fa, fb, p, q, rem, half, e, s;
        logic za, zb, ia, ib, na, nb;
        int sh;
        emax  = (longint'(1) << ew) - 1;
        bias  = (longint'(1) << (ew - 1)) - 1;
        fmask = (longint'(1) << mw) - 1;
        ea = (longint'(a) >> mw) & emax;
        eb = (longint'(b) >> mw) & emax;
        fa = longint'(a) & fmask;
        fb = longint'(b) & fmask;
        s  = longint'(a[ew+mw] ^ b[ew+mw]);
        za = (ea == 0);            zb = (eb == 0);
        ia = (ea == emax) && (fa == 0); ib = (eb == emax) && (fb == 0);
        na = (ea == emax) && (fa != 0); nb = (eb == emax) && (fb != 0);
        ov = 1'b0; un = 1'b0; ex = 1'b0;
        if (na || nb || (ia && zb) || (ib && za)) begin
            r  = 32'((emax << mw) | (longint'(1) << (mw - 1)));
            ex = 1'b1;
        end else if (ia || ib) begin
            r = 32'((s << (ew + mw)) | (emax << mw));
        end else if (za || zb) begin
            r = 32'(s << (ew + mw));
        end else begin
            p = ((longint'(1) << mw) | fa) * ((longint'(1) << mw) | fb);
            e = ea + eb - bias;
            if (p >= (longint'(1) << (2 * mw + 1))) begin
                sh = mw + 1;
                e  = e + 1;
            end else begin
                sh = mw;
            end
            q    = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == (longint'(1) << (mw + 1))) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e >= emax) begin
                r  = 32'((s << (ew + mw)) | (emax << mw));
                ov = 1'b1;
            end else if (e <= 0) begin
                r  = 32'(s << (ew + mw));
                un = 1'b1;
            end else begin
                r = 32'((s << (ew + mw)) | (e << mw) | (q & fmask));
            end
        end
    endfunction

    // expected-result state shared by drivers and compare processes
    logic        sp_pend = 1'b0, hp_pend = 1'b0;
    int          sp_cnt = 0, hp_cnt = 0;
    logic [31:0] sp_er, hp_er;
    logic        sp_eov, sp_eun, sp_eex, hp_eov, hp_eun, hp_eex;

    // compare single precision against the model on completion
    always @(posedge clk) begin
        #1;
        if (sp_pend) begin
            sp_cnt++;
            if (sp_done) begin
                check("sp_latency", 64'(sp_cnt), 64'd3);
                check("sp_res", 64'(sp_res), 64'(sp_er));
                check("sp_flags", 64'({sp_ov, sp_un, sp_ex}), 64'({sp_eov, sp_eun, sp_eex}));
                sp_pend = 1'b0;
            end else if (sp_cnt > 5) begin
                check("sp_timeout", 64'(sp_done), 64'd1);
                sp_pend = 1'b0;
            end
        end
    end

    // compare half precision against the model on completion
    always @(posedge clk) begin
        #1;
        if (hp_pend) begin
            hp_cnt++;
            if (hp_done) begin
                check("hp_latency", 64'(hp_cnt), 64'd3);
                check("hp_res", 64'(hp_res), 64'(hp_er[15:0]));
                check("hp_flags", 64'({hp_ov, hp_un, hp_ex}), 64'({hp_eov, hp_eun, hp_eex}));
                hp_pend = 1'b0;
            end else if (hp_cnt > 5) begin
                check("hp_timeout", 64'(hp_done), 64'd1);
                hp_pend = 1'b0;
            end
        end
    end

    // drive one start on the next edge and arm the expectation (call at a negedge)
    task automatic arm_sp(input logic [31:0] a, input logic [31:0] b);
        fp_model(8, 23, a, b, sp_er, sp_eov, sp_eun, sp_eex);
        sp_a = a; sp_b = b; sp_start = 1'b1;
        sp_cnt = 0; sp_pend = 1'b1;
    endtask

    task automatic run_sp(input logic [31:0] a, input logic [31:0] b);
        arm_sp(a, b);
        @(negedge clk);
        sp_start = 1'b0;
        for (int i = 0; i < 8 && sp_pend; i++) @(negedge clk);
    endtask

    task automatic run_hp(input logic [15:0] a, input logic [15:0] b);
        fp_model(5, 10, {16'h0, a}, {16'h0, b}, hp_er, hp_eov, hp_eun, hp_eex);
        hp_a = a; hp_b = b; hp_start = 1'b1;
        hp_cnt = 0; hp_pend = 1'b1;
        @(negedge clk);
        hp_start = 1'b0;
        for (int i = 0; i < 8 && hp_pend; i++) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] a, b, r;
        logic [2:0]  f;   // {overflow, underflow, exception}
    } vec_t;

    vec_t sp_vecs[11] = '{
        '{32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000},
        '{32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000},
        '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000},
        '{32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b000},
        '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100},
        '{32'h00800000, 32'h00800000, 32'h00000000, 3'b010},
        '{32'h80800000, 32'h00800000, 32'h80000000, 3'b010},
        '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001},
        '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000},
        '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 3'b001},
        '{32'h00000000, 32'hC0000000, 32'h80000000, 3'b000}
    };

    vec_t hp_vecs[2] = '{
        '{32'h3E00, 32'h4000, 32'h4200, 3'b000},
        '{32'h7800, 32'h7800, 32'h7C00, 3'b100}
    };

    initial begin
        logic [31:0] mr;
        logic        mo, mu, me;
        int          bad_seen;

        repeat (2) @(negedge clk);
        check("rst_done", 64'(sp_done), 64'd1);
        check("rst_res", 64'(sp_res), 64'd0);
        check("rst_flags", 64'({sp_ov, sp_un, sp_ex}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // pin the model with hand-computed results, then run the same vectors on the DUT
        foreach (sp_vecs[i]) begin
            fp_model(8, 23, sp_vecs[i].a, sp_vecs[i].b, mr, mo, mu, me);
            check($sformatf("model_sp%0d", i), 64'({mr, mo, mu, me}), 64'({sp_vecs[i].r, sp_vecs[i].f}));
            run_sp(sp_vecs[i].a, sp_vecs[i].b);
        end
        foreach (hp_vecs[i]) begin
            fp_model(5, 10, hp_vecs[i].a, hp_vecs[i].b, mr, mo, mu, me);
            check($sformatf("model_hp%0d", i), 64'({mr, mo, mu, me}), 64'({hp_vecs[i].r, hp_vecs[i].f}));
            run_hp(hp_vecs[i].a[15:0], hp_vecs[i].b[15:0]);
        end

        // restart: 1.5*2.0 immediately replaced by 2.0*2.0; the first product must never appear
        run_sp(32'h3F800000, 32'h3F800000);
        arm_sp(32'h3FC00000, 32'h40000000);
        @(negedge clk);
        arm_sp(32'h40000000, 32'h40000000);
        check("restart_expect", 64'(sp_er), 64'h40800000);
        bad_seen = 0;
        @(negedge clk);
        sp_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (sp_res == 32'h40400000) bad_seen++;
            @(negedge clk);
        end
        check("restart_no_stale", 64'(bad_seen), 64'd0);
        check("restart_idle", 64'(sp_pend), 64'd0);

        // reset one cycle after start aborts the op
        arm_sp(32'h3FC00000, 32'h40000000);
        @(negedge clk);
        sp_start = 1'b0;
        sp_pend = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_done", 64'(sp_done), 64'd1);
        check("abort_res", 64'(sp_res), 64'd0);
        check("abort_flags", 64'({sp_ov, sp_un, sp_ex}), 64'd0);
        repeat (4) @(negedge clk);
        check("abort_no_result", 64'({sp_done, sp_res}), 64'({1'b1, 32'h0}));

        // randomised half-precision operands
        for (int i = 0; i < 10000; i++)
            run_hp(16'($urandom), 16'($urandom));

        // randomised single-precision operands with exponents near the bias
        for (int i = 0; i < 300; i++)
            run_sp({1'($urandom), 8'($urandom_range(60, 190)), 23'($urandom)},
                   {1'($urandom), 8'($urandom_range(60, 190)), 23'($urandom)});

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_mul_rne.md
Name: fp_mul_rne

Overview:
- Parametrised IEEE-754-style floating-point multiplier. Successor to the fixed single-precision multiplier.
- Generalised exponent/mantissa widths; round-to-nearest-even; real overflow, underflow and exception flags; signed zero/infinity/NaN handling.
- Sits beside the other FPU arithmetic units under the same start/done handshake, fixed 3-cycle latency.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored mantissa (fraction) width; word width DATA_W = 1+EXP_W+MAN_W (derived, not overridable).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; op_a/op_b sampled on the same edge
- done  output  1  high when idle/result valid, low while busy
- op_a  input  DATA_W  operand A {sign, exp, frac}
- op_b  input  DATA_W  operand B
- overflow  output  1  result exponent exceeded max finite, saturated to infinity
- underflow  output  1  result below min normal, flushed to zero
- exception  output  1  invalid operation (NaN operand or inf*0)
- res  output  DATA_W  packed result

Behaviour:
- Reset (synchronous, rst=1 at edge): done=1, res=0, overflow=underflow=exception=0, pipeline occupancy cleared. Reset mid-operation aborts it; no result is produced.
- Handshake: start sampled at edge T.
  - done=0 during cycles T+1, T+2.
  - res and flags update at edge T+2; done=1 from cycle T+3.
  - res and flags hold until the next completion.
- Restart: start while busy discards the in-flight op. New operands are captured and the latency counter restarts. Only the last op completes; done stays low until 3 cycles after the last start.
- Stage 1 (edge T): register sign, exp and frac of both operands, plus classification per operand.
  - exp=0 → zero (subnormals flushed to zero).
  - exp=all-ones, frac=0 → inf.
  - exp=all-ones, frac≠0 → NaN.
- Stage 2 (edge T+1): register the following.
  - sign = sa^sb.
  - exp_sum = ea+eb-bias, signed, EXP_W+2 bits.
  - product = {1,fa}*{1,fb}, 2*(MAN_W+1) bits.
  - Special-case code.
- Stage 3 (edge T+2), normalise, round, pack:
  - If product MSB=1, take frac from bits below the MSB and set exp_sum+1. Else shift by one.
  - Guard = first bit below the kept fraction; sticky = OR of all remaining lower bits.
  - RNE: increment when guard & (sticky | frac LSB). A fraction carry-out sets frac=0 and exp+1.
  - Final exp ≥ 2^EXP_W-1 → res = {sign, all-ones, 0}, overflow=1.
  - Final exp ≤ 0 → res = {sign, 0, 0}, underflow=1.
  - Flags clear whenever their condition is absent for the completing op.
- Special-case priority:
  - Any NaN, or inf×zero → res = {0, all-ones, 1, 0…0} (canonical qNaN), exception=1.
  - Else any inf → signed inf, all flags 0.
  - Else any zero → signed zero, flags 0.
  - Else normal path.
- Flags are mutually exclusive.
- Unsigned widths: product never truncated before normalisation. Exponent arithmetic is wide enough that 2*(2^EXP_W-2)-bias+1 never wraps.

Test Plan:
- Basic and tie-rounding cases (EXP_W=8, MAN_W=23); all flags 0, done low 2 cycles then high:
  - 0x3FC00000×0x40000000 → 0x40400000.
  - 0xC0000000×0x40400000 → 0xC0C00000.
  - 0x3F800001×0x3F800001 → 0x3F800002.
  - 0x3FC00000×0x3F800001 → 0x3FC00002 (tie, rounds to even).
- Overflow/underflow:
  - 0x7F000000×0x7F000000 → res 0x7F800000, overflow=1.
  - 0x00800000×0x00800000 → res 0x00000000, underflow=1.
  - 0x80800000×0x00800000 → 0x80000000, underflow=1.
- Specials:
  - 0x7F800000×0x00000000 → 0x7FC00000, exception=1.
  - 0xFF800000×0x40000000 → 0xFF800000.
  - 0x7FA00000×0x3F800000 → 0x7FC00000, exception=1.
  - 0x00000000×0xC0000000 → 0x80000000.
- Restart/reset:
  - start at T with 1.5×2.0, start at T+1 with 2.0×2.0 → done low T+1..T+3, res=0x40800000 at T+4; 0x40400000 never presented.
  - rst at T+1 → next cycle done=1, res=0, flags 0.
- Parametric: EXP_W=5, MAN_W=10 (half precision).
  - 0x3E00×0x4000 → 0x4200.
  - 0x7800×0x7800 → 0x7C00, overflow=1.
  - Randomised 10k ops against a reference model, bit-exact.
